// File: rtl/mux_arb.sv
// N-channel registered mux with valid/ready, fixed-select or round-robin grant.
// Define MUX_ARB_LOCK_EN to add in_last/out_last and packet-level grant locking.

// Per-channel ready qualifier: a channel is ready only when it holds the grant
// and the output register can take a beat this cycle.
module mux_arb_lane #(
  parameter int SEL_WIDTH = 2,
  parameter int IDX       = 0
) (
  input  logic                 gnt_any,
  input  logic [SEL_WIDTH-1:0] gnt_idx,
  input  logic                 load_en,
  output logic                 ready
);
  assign ready = gnt_any && load_en && (gnt_idx == SEL_WIDTH'(IDX));
endmodule

module mux_arb #(
  parameter int WIDTH     = 32,
  parameter int NUM_CH    = 4,
  parameter int SEL_WIDTH = $clog2(NUM_CH),
  parameter int MODE      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [SEL_WIDTH-1:0]    sel,
`ifdef MUX_ARB_LOCK_EN
  input  logic [NUM_CH-1:0]       in_last,
  output logic                    out_last,
`endif
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_WIDTH-1:0]    out_ch
);

  logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
  logic [SEL_WIDTH-1:0]         ptr;
  logic [SEL_WIDTH-1:0]         gnt_idx;
  logic                         gnt_any;
  logic                         load_en;
  logic                         xfer;
  logic [WIDTH-1:0]             gnt_data;
  logic                         locked;
  logic [SEL_WIDTH-1:0]         lock_ch;

  assign ch_data = in_data;
  // Reset cycle must not accept a beat, so the register enable is gated by rst.
  assign load_en = (!out_valid || out_ready) && !rst;
  assign xfer    = gnt_any && load_en;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (locked) begin
      for (int i = 0; i < NUM_CH; i++)
        if (lock_ch == SEL_WIDTH'(i)) begin
          gnt_any = in_valid[i];
          gnt_idx = lock_ch;
        end
    end else if (MODE == 0) begin
      // sel values at or above NUM_CH match no channel and so grant nothing.
      for (int i = 0; i < NUM_CH; i++)
        if (sel == SEL_WIDTH'(i) && in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = sel;
        end
    end else begin
      // Walk the search order backwards so the nearest successor of ptr wins.
      for (int k = NUM_CH; k >= 1; k--) begin
        if (in_valid[(int'(ptr) + k) % NUM_CH]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_WIDTH'((int'(ptr) + k) % NUM_CH);
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (gnt_idx == SEL_WIDTH'(i)) gnt_data = ch_data[i];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    mux_arb_lane #(
      .SEL_WIDTH (SEL_WIDTH),
      .IDX       (i)
    ) u_lane (
      .gnt_any (gnt_any),
      .gnt_idx (gnt_idx),
      .load_en (load_en),
      .ready   (in_ready[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SEL_WIDTH'(NUM_CH - 1);
    end else if (load_en) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_ch    <= gnt_idx;
        ptr       <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_ARB_LOCK_EN
  logic gnt_last;

  always_comb begin
    gnt_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (gnt_idx == SEL_WIDTH'(i)) gnt_last = in_last[i];
  end

  // A non-final beat pins the grant to its channel until the final beat moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked   <= 1'b0;
      lock_ch  <= '0;
      out_last <= 1'b0;
    end else if (xfer) begin
      locked   <= !gnt_last;
      lock_ch  <= gnt_idx;
      out_last <= gnt_last;
    end
  end
`else
  assign locked  = 1'b0;
  assign lock_ch = '0;
`endif

endmodule

// File: tb/tb_mux_arb.sv
// Directed bench for mux_arb: fixed select, round-robin, backpressure,
// out-of-range select, mid-stream reset, and packet lock when enabled.
module tb_mux_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // a: MODE 0, 4 channels
  logic         a_rst, a_out_ready, a_out_valid;
  logic [127:0] a_data;
  logic [3:0]   a_valid, a_in_ready;
  logic [1:0]   a_sel, a_out_ch;
  logic [31:0]  a_out_data;
  // b: MODE 1, 4 channels
  logic         b_rst, b_out_ready, b_out_valid;
  logic [127:0] b_data;
  logic [3:0]   b_valid, b_in_ready;
  logic [1:0]   b_sel, b_out_ch;
  logic [31:0]  b_out_data;
  // c: MODE 0, 3 channels
  logic         c_rst, c_out_ready, c_out_valid;
  logic [95:0]  c_data;
  logic [2:0]   c_valid, c_in_ready;
  logic [1:0]   c_sel, c_out_ch;
  logic [31:0]  c_out_data;
`ifdef MUX_ARB_LOCK_EN
  logic [3:0] a_last, b_last;
  logic [2:0] c_last;
  logic       a_out_last, b_out_last, c_out_last;
`endif

  mux_arb #(.WIDTH(32), .NUM_CH(4), .MODE(0)) u_a (
    .clk(clk), .rst(a_rst), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_in_ready), .sel(a_sel),
`ifdef MUX_ARB_LOCK_EN
    .in_last(a_last), .out_last(a_out_last),
`endif
    .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_ch(a_out_ch));

  mux_arb #(.WIDTH(32), .NUM_CH(4), .MODE(1)) u_b (
    .clk(clk), .rst(b_rst), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_in_ready), .sel(b_sel),
`ifdef MUX_ARB_LOCK_EN
    .in_last(b_last), .out_last(b_out_last),
`endif
    .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_ch(b_out_ch));

  mux_arb #(.WIDTH(32), .NUM_CH(3), .MODE(0)) u_c (
    .clk(clk), .rst(c_rst), .in_data(c_data), .in_valid(c_valid),
    .in_ready(c_in_ready), .sel(c_sel),
`ifdef MUX_ARB_LOCK_EN
    .in_last(c_last), .out_last(c_out_last),
`endif
    .out_data(c_out_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_ch(c_out_ch));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int rr_a [6];
    int rr_b [4];
    rr_a = '{0, 1, 2, 3, 0, 1};
    rr_b = '{3, 1, 3, 1};

    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_valid = '0; b_valid = '0; c_valid = '0;
    a_sel = '0; b_sel = '0; c_sel = '0;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_data[i*32 +: 32] = 32'hA0 + i;
      b_data[i*32 +: 32] = 32'hB0 + i;
    end
    for (int i = 0; i < 3; i++) c_data[i*32 +: 32] = 32'hC0 + i;
`ifdef MUX_ARB_LOCK_EN
    a_last = '1; b_last = '1; c_last = '1;
`endif
    tick(); tick();

    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_data", a_out_data, 0);
    chk("rst_a_ch", a_out_ch, 0);
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_in_ready", b_in_ready, 0);
`ifdef MUX_ARB_LOCK_EN
    chk("rst_b_last", b_out_last, 0);
`endif
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // fixed select sequence 2,0,3
    a_valid = 4'hF; a_sel = 2'd2;
    #1 chk("a_rdy_sel2", a_in_ready, 4'b0100);
    tick(); chk("a_d2", a_out_data, 32'hA2); chk("a_c2", a_out_ch, 2); chk("a_v2", a_out_valid, 1);
    a_sel = 2'd0;
    tick(); chk("a_d0", a_out_data, 32'hA0); chk("a_c0", a_out_ch, 0);
    a_sel = 2'd3;
    tick(); chk("a_d3", a_out_data, 32'hA3); chk("a_c3", a_out_ch, 3);

    // backpressure: hold DEADBEEF for 3 cycles, then take the next beat once
    a_data[32 +: 32] = 32'hDEADBEEF; a_sel = 2'd1;
    tick(); chk("bp_load", a_out_data, 32'hDEADBEEF);
    a_out_ready = 1'b0; a_data[64 +: 32] = 32'h12345678; a_sel = 2'd2;
    #1 chk("bp_rdy0", a_in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_d", a_out_data, 32'hDEADBEEF);
      chk("bp_hold_v", a_out_valid, 1);
      chk("bp_hold_c", a_out_ch, 1);
      chk("bp_hold_r", a_in_ready, 0);
    end
    a_out_ready = 1'b1;
    #1 chk("bp_rel_rdy", a_in_ready, 4'b0100);
    tick(); chk("bp_next_d", a_out_data, 32'h12345678); chk("bp_next_c", a_out_ch, 2);
    a_valid = '0;
    #1 chk("idle_rdy", a_in_ready, 0);
    tick(); chk("drain_v", a_out_valid, 0); chk("drain_hold_d", a_out_data, 32'h12345678);
    chk("drain_hold_c", a_out_ch, 2);

    // round-robin, all valid then only ch1/ch3
    b_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_all_ch", b_out_ch, rr_a[k]);
      chk("rr_all_d", b_out_data, 32'hB0 + rr_a[k]);
    end
    b_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_odd_ch", b_out_ch, rr_b[k]);
    end

    // mid-stream reset
    b_valid = 4'hF; b_rst = 1'b1;
    #1 chk("rst_mid_rdy", b_in_ready, 0);
    tick(); chk("rst_mid_v", b_out_valid, 0); chk("rst_mid_d", b_out_data, 0);
    b_rst = 1'b0;
    tick(); chk("rst_mid_ch0", b_out_ch, 0); chk("rst_mid_v1", b_out_valid, 1);

    // 3 channels, out-of-range select
    c_valid = 3'b111; c_sel = 2'd0;
    tick(); chk("c_v", c_out_valid, 1); chk("c_d0", c_out_data, 32'hC0);
    c_sel = 2'd3;
    #1 chk("c_sel3_rdy", c_in_ready, 0);
    tick(); chk("c_sel3_v", c_out_valid, 0); chk("c_sel3_hold", c_out_ch, 0);

`ifdef MUX_ARB_LOCK_EN
    // ch1 sends a 3-beat packet while ch0/ch2 are also requesting
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0; b_valid = 4'b0111; b_last = 4'b1101;
    tick(); chk("lk_c0", b_out_ch, 0); chk("lk_l0", b_out_last, 1);
    tick(); chk("lk_c1a", b_out_ch, 1); chk("lk_l1a", b_out_last, 0);
    tick(); chk("lk_c1b", b_out_ch, 1); chk("lk_l1b", b_out_last, 0);
    b_last = 4'b1111;
    tick(); chk("lk_c1c", b_out_ch, 1); chk("lk_l1c", b_out_last, 1);
    tick(); chk("lk_c2", b_out_ch, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arb.md
# mux_arb

Parametrised N-channel registered multiplexer with valid/ready handshaking, successor to the plain 2:1 combinational mux. Selects one of `NUM_CH` input streams per cycle, either under explicit `sel` control or by round-robin arbitration, and delivers the winning beat through a single output register. Sits between multiple producers and one downstream consumer on the datapath.

## Interface
- `WIDTH`, 32, data width per channel
- `NUM_CH`, 4, number of input channels (2..16)
- `SEL_WIDTH`, `$clog2(NUM_CH)`, width of `sel`/`out_ch`
- `MODE`, 0, 0 = fixed select via `sel`; 1 = round-robin arbitration (`sel` ignored)

- `clk`  in  1  clock; all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  NUM_CH*WIDTH  channel i at `[i*WIDTH +: WIDTH]`
- `in_valid`  in  NUM_CH  per-channel valid
- `in_ready`  out  NUM_CH  per-channel ready; one-hot or zero
- `sel`  in  SEL_WIDTH  channel select (MODE 0 only)
- `out_data`  out  WIDTH  registered output beat
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts
- `out_ch`  out  SEL_WIDTH  source channel of current output beat

## Operation
- `load_en = !out_valid || out_ready` (output register empty or draining this cycle).
- Grant (combinational): MODE 0: channel `sel` if `sel < NUM_CH` and `in_valid[sel]`; `sel >= NUM_CH` -> no grant. MODE 1: first channel with `in_valid` set, searching `ptr+1, ptr+2, …` modulo `NUM_CH`.
- `in_ready[g] = load_en` for granted channel g only; all other bits 0. No grant -> `in_ready` = 0.
- Transfer on channel g (`in_valid[g] && in_ready[g]`): `out_data <= in_data[g]`, `out_ch <= g`, `out_valid <= 1`, `ptr <= g`.
- `load_en` with no grant: `out_valid <= 0`; `out_data`/`out_ch` hold.
- `!load_en`: `out_data`, `out_ch`, `out_valid`, `ptr` all hold; in_ready all 0.
- `ptr` updates only on transfer; wraps `NUM_CH-1 -> 0`.
- Reset values: `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=NUM_CH-1` (so channel 0 wins first), lock state cleared.

## Timing
- Latency: 1 cycle from accepted input beat to `out_valid`.
- Throughput: 1 beat/cycle with `out_ready` held high.
- `in_ready` depends combinationally on `in_valid`, `sel`, `out_ready`; `out_*` are register outputs only.
- `sel` change takes effect same cycle for grant; an already-registered beat is unaffected.
- Input withdrawing `in_valid` before transfer is legal (no transfer occurs).
- `rst` asserted mid-stream: next edge discards the registered beat (`out_valid=0`); no beat accepted in the reset cycle (`in_ready=0` while `rst=1`).

## Configuration
- `MUX_ARB_LOCK_EN` defined: adds ports `in_last` (in, NUM_CH) and `out_last` (out, 1, registered with the beat, reset 0). A transfer with `in_last[g]=0` locks grant to g; while locked only g may be granted (overrides `sel` and round-robin); transfer with `in_last[g]=1` releases lock. Reset clears lock.
- Not defined: no `in_last`/`out_last` ports; every beat arbitrated independently.

## Test plan
- MODE 0, NUM_CH=4, all valid, data=32'hA0..A3, `sel` 2,0,3 over 3 cycles, `out_ready=1` -> out_data A2,A0,A3 one cycle later, out_ch 2,0,3.
- MODE 1, all 4 channels valid continuously -> grant order 0,1,2,3,0,1; only ch1,ch3 valid -> 1,3,1,3.
- `out_ready=0` for 3 cycles with beat 32'hDEADBEEF registered -> out_data/out_valid/out_ch stable, `in_ready`=0; release -> next beat on following edge, no loss or duplication.
- MODE 0, NUM_CH=3, `sel=3` with all valid -> in_ready=0, out_valid falls to 0 after draining.
- `rst` pulsed for 1 cycle mid-stream -> out_valid=0, out_data=0, next MODE 1 grant is channel 0.
- `MUX_ARB_LOCK_EN`, MODE 1: ch1 sends 3 beats (last on 3rd) while ch0,ch2 valid -> out_ch 1,1,1 then 2; out_last high only on third beat.
